// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition sequencer: state encoding and counter sizing.
package acq_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } acq_state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_det.sv
// Single-edge detector: registers the input once and flags a rising or falling transition.
module edge_det #(
  parameter bit RISING = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) d_p0 <= 1'b0;
    else      d_p0 <= d;
  end

  assign pulse = RISING ? (d & ~d_p0) : (~d & d_p0);

endmodule

// File: rtl/acq_sequencer.sv
// Multi-pulse acquisition sequencer: arms on request, starts one capture per laser trigger,
// waits for the input pipeline to drain, and counts completed and missed pulses.
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int CAPTURE_CYCLES = 100,
  parameter int DRAIN_TIMEOUT  = 4096,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             abort,
  input  logic             trig,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic             pipe_valid,
  output logic             start,
  output logic             accum_first,
  output logic             accum_last,
  output logic [CNT_W-1:0] pulse_idx,
  output logic [CNT_W-1:0] missed_cnt,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  localparam int CAP_W = cnt_bits(CAPTURE_CYCLES);
  localparam int DRN_W = cnt_bits(DRAIN_TIMEOUT);
  localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'(CAPTURE_CYCLES - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  acq_state_t       state, state_nxt;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] pulse_idx_nxt, missed_nxt, pulse_inc;
  logic [CAP_W-1:0] cap_cnt, cap_nxt;
  logic [DRN_W-1:0] drain_cnt, drain_nxt;
  logic             start_nxt, first_nxt, last_nxt, done_nxt, terr_nxt;
  logic             load_target;
  logic             trig_rise, pv_fall;

  edge_det #(.RISING(1'b1)) u_trig_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (trig),
    .pulse (trig_rise)
  );

  edge_det #(.RISING(1'b0)) u_pv_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (pipe_valid),
    .pulse (pv_fall)
  );

  assign pulse_inc = pulse_idx + CNT_W'(1);

  always_comb begin
    state_nxt     = state;
    start_nxt     = 1'b0;
    first_nxt     = 1'b0;
    last_nxt      = 1'b0;
    done_nxt      = 1'b0;
    terr_nxt      = timeout_err;
    pulse_idx_nxt = pulse_idx;
    missed_nxt    = missed_cnt;
    cap_nxt       = cap_cnt;
    drain_nxt     = drain_cnt;
    load_target   = 1'b0;
    // abort outranks every other request and leaves the counters untouched
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            if (num_pulses != '0) begin
              load_target   = 1'b1;
              pulse_idx_nxt = '0;
              missed_nxt    = '0;
              terr_nxt      = 1'b0;
              state_nxt     = ST_ARMED;
            end else begin
              done_nxt = 1'b1;
            end
          end
        end
        ST_ARMED: begin
          if (trig_rise) begin
            start_nxt = 1'b1;
            first_nxt = (pulse_idx == '0);
            last_nxt  = (pulse_idx == target - CNT_W'(1));
            cap_nxt   = '0;
            state_nxt = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (trig_rise) missed_nxt = sat_inc(missed_cnt);
          if (cap_cnt == CAP_LAST) begin
            drain_nxt = '0;
            state_nxt = ST_DRAIN;
          end else begin
            cap_nxt = cap_cnt + CAP_W'(1);
          end
        end
        ST_DRAIN: begin
          if (trig_rise) missed_nxt = sat_inc(missed_cnt);
          if (pv_fall) begin
            pulse_idx_nxt = pulse_inc;
            if (pulse_inc == target) begin
              done_nxt  = 1'b1;
              state_nxt = ST_DONE;
            end else begin
              state_nxt = ST_ARMED;
            end
          end else if (drain_cnt == DRN_LAST) begin
            terr_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            drain_nxt = drain_cnt + DRN_W'(1);
          end
        end
        ST_DONE: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      start       <= 1'b0;
      accum_first <= 1'b0;
      accum_last  <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      pulse_idx   <= '0;
      missed_cnt  <= '0;
      cap_cnt     <= '0;
      drain_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      start       <= start_nxt;
      accum_first <= first_nxt;
      accum_last  <= last_nxt;
      done        <= done_nxt;
      timeout_err <= terr_nxt;
      pulse_idx   <= pulse_idx_nxt;
      missed_cnt  <= missed_nxt;
      cap_cnt     <= cap_nxt;
      drain_cnt   <= drain_nxt;
    end
  end

  // Run length is data, only meaningful after an accepted arm.
  always_ff @(posedge clk) begin
    if (load_target) target <= num_pulses;
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: doc/acq_sequencer.md
ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 The block SHALL have parameter CAPTURE_CYCLES, default 100: clocks per pulse during which the input buffer is written (half the per-pulse sample count, 2 samples/clk).
REQ-002 The block SHALL have parameter DRAIN_TIMEOUT, default 4096: maximum clocks allowed in DRAIN before the run is declared failed.
REQ-003 The block SHALL have parameter CNT_W, default 16: width of the pulse and miss counters.
REQ-004 The block SHALL have port clk, input, 1: the single clock for all logic.
REQ-005 The block SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-006 The block SHALL have port arm, input, 1: one-cycle run request.
REQ-007 The block SHALL have port abort, input, 1: one-cycle run cancel.
REQ-008 The block SHALL have port trig, input, 1: laser sync level, synchronous to clk.
REQ-009 The block SHALL have port num_pulses, input, CNT_W: pulses to accumulate, sampled on accepted arm.
REQ-010 The block SHALL have port pipe_valid, input, 1: data_valid from the input buffer.
REQ-011 The block SHALL have port start, output, 1: one-cycle capture start to the input buffer.
REQ-012 The block SHALL have ports accum_first and accum_last, output, 1 each: accumulator clear/final flags, valid with start.
REQ-013 The block SHALL have port pulse_idx, output, CNT_W: count of completed pulses in the current run.
REQ-014 The block SHALL have port missed_cnt, output, CNT_W: count of triggers ignored while busy.
REQ-015 The block SHALL have ports busy (level), done (one-cycle pulse) and timeout_err (sticky), output, 1 each.

Function
REQ-016 The block SHALL implement states IDLE, ARMED, CAPTURE, DRAIN, DONE.
REQ-017 The block SHALL detect a trigger edge as trig high with registered trig low.
REQ-018 In IDLE, arm with num_pulses!=0 SHALL latch num_pulses, clear pulse_idx, missed_cnt and timeout_err, and move to ARMED.
REQ-019 In IDLE, arm with num_pulses==0 SHALL pulse done the next cycle and remain in IDLE.
REQ-020 In ARMED, a trigger edge SHALL register start=1 on the next clock and move to CAPTURE.
REQ-021 With start, accum_first SHALL equal (pulse_idx==0) and accum_last SHALL equal (pulse_idx==target-1).
REQ-022 CAPTURE SHALL last exactly CAPTURE_CYCLES clocks, counted from the start cycle, then move to DRAIN.
REQ-023 DRAIN SHALL wait for a pipe_valid falling edge, increment pulse_idx, and move to DONE if the new pulse_idx equals target, else to ARMED.
REQ-024 If DRAIN lasts DRAIN_TIMEOUT clocks without a pipe_valid fall, the block SHALL set timeout_err and move to IDLE without pulsing done.
REQ-025 In DONE, the block SHALL pulse done for one cycle and move to IDLE.
REQ-026 Trigger edges in CAPTURE or DRAIN SHALL increment missed_cnt, saturating at all-ones.
REQ-027 busy SHALL be high in every state except IDLE.
REQ-028 abort SHALL force IDLE on the next clock from any state, suppress done, and hold pulse_idx and missed_cnt.
REQ-029 abort SHALL take priority over arm and over a trigger edge in the same cycle.
REQ-030 arm outside IDLE SHALL be ignored.
REQ-031 A trigger edge coincident with an accepted arm SHALL be ignored.
REQ-032 The ARMED-to-CAPTURE transition SHALL be the only path that asserts start.

Reset
REQ-033 While rst is low, the block SHALL hold state IDLE, all counters 0, and start, accum_first, accum_last, busy, done and timeout_err at 0.
REQ-034 A reset asserted mid-run SHALL abandon the run with no done pulse.

Structure
REQ-035 State encoding and the CNT_W default SHALL live in shared package acq_pkg.
REQ-036 Trigger and pipe_valid edge detection SHALL use one reusable sub-module, edge_det.

Verification
REQ-037 Basic run: num_pulses=3, arm, 3 triggers spaced 400 clk, CAPTURE_CYCLES=100, pipe_valid high for 50 clk after each capture -> 3 start pulses; accum_first on the 1st, accum_last on the 3rd; pulse_idx ends 3; one done.
REQ-038 Zero pulses: num_pulses=0, arm -> done the next cycle, busy never high.
REQ-039 Trigger during CAPTURE: 2 extra triggers inside the window -> missed_cnt=2, start count unchanged.
REQ-040 Timeout: pipe_valid held low, DRAIN_TIMEOUT=64 -> timeout_err high 64 clk after entering DRAIN, state IDLE, no done.
REQ-041 Abort/reset: abort coincident with a trigger in ARMED -> no start, IDLE next clock, pulse_idx held; rst low during CAPTURE -> all outputs 0 immediately.
